// File: rtl/sdram_mem_tester.sv
//============================================================================
// sdram_mem_tester : write / read-back / verify engine driving SDRAM ctrl ports
// Rev 1.0
//============================================================================
`default_nettype none

module sdram_mem_tester #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024,
    parameter int ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     seed,
    input  logic [ADDR_W-1:0]     addr_start,
    input  logic [ADDR_W-1:0]     addr_end,
    input  logic                  stop_on_error,
    input  logic                  cmd_ready,
    output logic                  cmd_enable,
    output logic                  cmd_wr,
    output logic [ADDR_W-1:0]     cmd_address,
    output logic [DATA_W-1:0]     cmd_data_in,
    output logic [DATA_W/8-1:0]   cmd_byte_enable,
    input  logic [DATA_W-1:0]     data_out,
    input  logic                  data_out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_CNT_W-1:0]  error_count,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [DATA_W-1:0]     fail_expected,
    output logic [DATA_W-1:0]     fail_actual
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    function automatic logic [DATA_W-1:0] lfsr_taps(input int w);
        case (w)
            8:       return DATA_W'(8'hB8);
            16:      return DATA_W'(16'hB400);
            64:      return DATA_W'(64'hD800_0000_0000_0000);
            default: return DATA_W'(32'h8020_0003);
        endcase
    endfunction

    localparam logic [DATA_W-1:0] C_LFSR_TAPS = lfsr_taps(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // First pattern word of a pass; the read pass restarts from here.
    function automatic logic [DATA_W-1:0] pat_init(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [ADDR_W-1:0] a);
        case (m)
            2'd1:    return DATA_W'(a);
            2'd3:    return (s == '0) ? DATA_W'(1) : s;
            default: return s;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] p);
        case (m)
            2'd2:    return {p[DATA_W-2:0], p[DATA_W-1]};
            2'd3:    return (p >> 1) ^ (p[0] ? C_LFSR_TAPS : '0);
            default: return p + DATA_W'(1);
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [DATA_W-1:0]      seed_q, seed_d;
    logic [ADDR_W-1:0]      start_q, start_d;
    logic [ADDR_W-1:0]      end_q, end_d;
    logic                   stop_q, stop_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      pat_q, pat_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   cmd_enable_q, cmd_enable_d;
    logic                   cmd_wr_q, cmd_wr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]      fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]      fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0]      fail_act_q, fail_act_d;
    logic                   last_addr;
    logic                   mismatch;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        start_d      = start_q;
        end_d        = end_q;
        stop_d       = stop_q;
        addr_d       = addr_q;
        pat_d        = pat_q;
        tmo_cnt_d    = tmo_cnt_q;
        cmd_enable_d = cmd_enable_q;
        cmd_wr_d     = cmd_wr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        err_cnt_d    = err_cnt_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;
        mismatch     = 1'b0;
        last_addr    = (addr_q == end_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d      = mode;
                    seed_d      = seed;
                    start_d     = addr_start;
                    end_d       = addr_end;
                    stop_d      = stop_on_error;
                    addr_d      = addr_start;
                    pat_d       = pat_init(mode, seed, addr_start);
                    tmo_cnt_d   = '0;
                    timeout_d   = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                    if (addr_end < addr_start) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d      = S_WR_ISSUE;
                        busy_d       = 1'b1;
                        done_d       = 1'b0;
                        pass_d       = 1'b0;
                        cmd_enable_d = 1'b1;
                        cmd_wr_d     = 1'b1;
                    end
                end
            end
            S_WR_ISSUE: begin
                if (cmd_enable_q && cmd_ready) begin
                    if (last_addr) begin
                        // One idle cycle between the write and read passes.
                        cmd_enable_d = 1'b0;
                        cmd_wr_d     = 1'b0;
                        addr_d       = start_q;
                        pat_d        = pat_init(mode_q, seed_q, start_q);
                        state_d      = S_RD_ISSUE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        pat_d  = pat_next(mode_q, pat_q);
                    end
                end
            end
            S_RD_ISSUE: begin
                if (!cmd_enable_q) begin
                    cmd_enable_d = 1'b1;
                end else if (cmd_ready) begin
                    cmd_enable_d = 1'b0;
                    tmo_cnt_d    = '0;
                    state_d      = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (data_out_ready) begin
                    if (data_out != pat_q) begin
                        mismatch = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        if (err_cnt_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_exp_d  = pat_q;
                            fail_act_d  = data_out;
                        end
                    end
                    if ((mismatch && stop_q) || last_addr) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !mismatch && (err_cnt_q == '0);
                    end else begin
                        addr_d       = addr_q + ADDR_W'(1);
                        pat_d        = pat_next(mode_q, pat_q);
                        cmd_enable_d = 1'b1;
                        state_d      = S_RD_ISSUE;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            seed_q       <= '0;
            start_q      <= '0;
            end_q        <= '0;
            stop_q       <= 1'b0;
            addr_q       <= '0;
            pat_q        <= '0;
            tmo_cnt_q    <= '0;
            cmd_enable_q <= 1'b0;
            cmd_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            start_q      <= start_d;
            end_q        <= end_d;
            stop_q       <= stop_d;
            addr_q       <= addr_d;
            pat_q        <= pat_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cmd_enable_q <= cmd_enable_d;
            cmd_wr_q     <= cmd_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    assign cmd_enable      = cmd_enable_q;
    assign cmd_wr          = cmd_wr_q;
    assign cmd_address     = addr_q;
    assign cmd_data_in     = pat_q;
    assign cmd_byte_enable = '1;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign error_count     = err_cnt_q;
    assign fail_addr       = fail_addr_q;
    assign fail_expected   = fail_exp_q;
    assign fail_actual     = fail_act_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_mem_tester.sv
//============================================================================
// tb_sdram_mem_tester : SDRAM behavioural model plus scoreboard for the tester
// Rev 1.0
//============================================================================
`default_nettype none

module tb_sdram_mem_tester;

    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int TMO = 1024;
    localparam int EW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = '0;
    logic [DW-1:0]   seed = '0;
    logic [AW-1:0]   addr_start = '0;
    logic [AW-1:0]   addr_end = '0;
    logic            stop_on_error = 1'b0;
    logic            cmd_ready = 1'b0;
    logic [DW-1:0]   data_out = '0;
    logic            data_out_ready = 1'b0;
    logic            cmd_enable;
    logic            cmd_wr;
    logic [AW-1:0]   cmd_address;
    logic [DW-1:0]   cmd_data_in;
    logic [DW/8-1:0] cmd_byte_enable;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [EW-1:0]   error_count;
    logic [AW-1:0]   fail_addr;
    logic [DW-1:0]   fail_expected;
    logic [DW-1:0]   fail_actual;

    sdram_mem_tester #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .ERR_CNT_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .addr_start(addr_start), .addr_end(addr_end), .stop_on_error(stop_on_error),
        .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
        .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
        .cmd_byte_enable(cmd_byte_enable), .data_out(data_out),
        .data_out_ready(data_out_ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .error_count(error_count), .fail_addr(fail_addr),
        .fail_expected(fail_expected), .fail_actual(fail_actual)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t          exp_q[$];
    bit            corrupt[int];
    int            drop_addr = -1;
    logic [DW-1:0] mem[int];
    bit            rd_pending = 1'b0;
    int            rd_delay = 0;
    int            rd_addr = 0;
    int            cyc = 0;
    int            accept_cyc = 0;
    bit            saw_enable = 1'b0;
    bit            first_wr_wait = 1'b0;
    logic [DW-1:0] first_wr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: random cmd_ready, 3..8 cycle read latency, fault injection.
    initial begin : model
        cmd_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cmd_ready      = 1'b0;
                data_out_ready = 1'b0;
                rd_pending     = 1'b0;
            end else begin
                data_out_ready = 1'b0;
                if (rd_pending) begin
                    rd_delay--;
                    if (rd_delay == 0) begin
                        rd_pending = 1'b0;
                        if (rd_addr != drop_addr) begin
                            data_out = (mem.exists(rd_addr) ? mem[rd_addr] : '0)
                                       ^ (corrupt.exists(rd_addr) ? 32'h1 : 32'h0);
                            data_out_ready = 1'b1;
                        end
                    end
                end
                cmd_ready = ($urandom_range(0, 3) != 0);
                if (cmd_enable) saw_enable = 1'b1;
                if (cmd_enable && cmd_ready) begin
                    chk("cmd_expected", exp_q.size() != 0, 1);
                    chk("byte_enable", cmd_byte_enable, 64'hF);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("cmd_wr", cmd_wr, e.wr);
                        chk("cmd_address", cmd_address, e.addr);
                        if (e.wr) chk("cmd_data_in", cmd_data_in, e.data);
                    end
                    if (cmd_wr) begin
                        mem[int'(cmd_address)] = cmd_data_in;
                        if (first_wr_wait) begin
                            first_wr      = cmd_data_in;
                            first_wr_wait = 1'b0;
                        end
                    end else begin
                        chk("one_read_outstanding", rd_pending, 0);
                        rd_pending = 1'b1;
                        rd_delay   = $urandom_range(3, 8);
                        rd_addr    = int'(cmd_address);
                        accept_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic run_test(input int m, input logic [DW-1:0] sd, input int a, input int b,
                            input bit stop, input int drop, input bit mid_start);
        logic [DW-1:0] pats[$];
        logic [DW-1:0] p, lf, fe, fact;
        cmd_t          c;
        int            n, errs, fa;
        bit            tmo, ok;
        exp_q.delete();
        drop_addr = drop;
        n    = (b >= a) ? b - a + 1 : 0;
        lf   = (sd == '0) ? 32'h1 : sd;
        errs = 0; fa = 0; fe = '0; fact = '0; tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (m)
                0:       p = sd + DW'(i);
                1:       p = DW'(a + i);
                2:       p = (sd << (i % DW)) | (sd >> (DW - (i % DW)));
                default: begin
                    p  = lf;
                    lf = (lf >> 1) ^ (lf[0] ? 32'h8020_0003 : 32'h0);
                end
            endcase
            pats.push_back(p);
            c.wr = 1'b1; c.addr = AW'(a + i); c.data = p;
            exp_q.push_back(c);
        end
        for (int i = 0; i < n; i++) begin
            c.wr = 1'b0; c.addr = AW'(a + i); c.data = '0;
            exp_q.push_back(c);
            if (a + i == drop) begin
                tmo = 1'b1;
                break;
            end
            if (corrupt.exists(a + i)) begin
                if (errs == 0) begin
                    fa = a + i; fe = pats[i]; fact = pats[i] ^ 32'h1;
                end
                errs++;
                if (stop) break;
            end
        end

        @(negedge clk);
        mode = 2'(m); seed = sd; addr_start = AW'(a); addr_end = AW'(b);
        stop_on_error = stop; start = 1'b1;
        saw_enable = 1'b0; first_wr_wait = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            chk("empty_done_next_cycle", done, 1);
            chk("empty_pass", pass, 1);
            chk("empty_busy", busy, 0);
        end else begin
            chk("busy_after_start", busy, 1);
            chk("done_cleared", done, 0);
            chk("cmd_enable_after_start", cmd_enable, 1);
        end

        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (mid_start && k == 50) begin
                start = 1'b1; addr_start = '0; addr_end = '0; mode = 2'd2;
            end
            if (mid_start && k == 51) start = 1'b0;
            @(negedge clk);
        end
        chk("done_reached", ok, 1);
        chk("pass", pass, (errs == 0) && !tmo);
        chk("timeout", timeout, tmo);
        chk("error_count", error_count, errs);
        chk("fail_addr", fail_addr, fa);
        chk("fail_expected", fail_expected, fe);
        chk("fail_actual", fail_actual, fact);
        chk("busy_at_done", busy, 0);
        chk("all_cmds_issued", exp_q.size(), 0);
        if (tmo) chk("timeout_latency", cyc - accept_cyc, TMO);
        repeat (3) @(negedge clk);
        chk("no_cmds_after_done", exp_q.size(), 0);
        chk("done_held", done, 1);
        drop_addr = -1;
    endtask

    initial begin
        cmd_t c;
        repeat (3) @(negedge clk);
        chk("rst_cmd_enable", cmd_enable, 0);
        chk("rst_cmd_wr", cmd_wr, 0);
        chk("rst_cmd_address", cmd_address, 0);
        chk("rst_cmd_data_in", cmd_data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_expected", fail_expected, 0);
        chk("rst_fail_actual", fail_actual, 0);
        rst = 1'b1;

        run_test(0, 32'h100, 'h10, 'h1F, 1'b0, -1, 1'b0);
        chk("mode0_word_at_1f", mem['h1F], 32'h10F);

        corrupt['h14] = 1'b1;
        run_test(1, 32'h0, 'h10, 'h1F, 1'b0, -1, 1'b0);
        chk("mode1_fail_expected_lit", fail_expected, 32'h14);
        chk("mode1_fail_actual_lit", fail_actual, 32'h15);
        chk("mode1_error_count_lit", error_count, 1);
        corrupt.delete();

        corrupt['h12] = 1'b1;
        corrupt['h18] = 1'b1;
        run_test(0, 32'hDEAD_0000, 'h10, 'h1F, 1'b1, -1, 1'b0);
        chk("stop_fail_addr_lit", fail_addr, 'h12);
        chk("stop_error_count_lit", error_count, 1);
        corrupt.delete();

        run_test(3, 32'h0, 0, 255, 1'b0, -1, 1'b0);
        chk("lfsr_first_write_lit", first_wr, 32'h1);
        chk("lfsr_second_write_lit", mem[1], 32'h8020_0003);
        chk("lfsr_pass_lit", pass, 1);

        run_test(2, 32'h1, 0, 40, 1'b0, -1, 1'b0);
        chk("walk_addr33_lit", mem[33], 32'h2);
        chk("walk_addr31_lit", mem[31], 32'h8000_0000);

        run_test(0, 32'h0, 0, 7, 1'b0, 5, 1'b1);
        chk("drop_timeout_lit", timeout, 1);
        chk("drop_pass_lit", pass, 0);

        run_test(0, 32'h0, 'h20, 'h1F, 1'b0, -1, 1'b0);
        chk("empty_no_cmd_enable", saw_enable, 0);

        // Abort a long write pass with an asynchronous reset.
        exp_q.delete();
        for (int i = 0; i <= 100; i++) begin
            c.wr = 1'b1; c.addr = AW'(i); c.data = DW'(i);
            exp_q.push_back(c);
        end
        @(negedge clk);
        mode = 2'd0; seed = '0; addr_start = '0; addr_end = AW'(100);
        stop_on_error = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_cmd_enable", cmd_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wrote_some", exp_q.size() < 101, 1);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", cmd_enable, 0);

        run_test(1, 32'h0, 'h7FFFF0, 'h7FFFFF, 1'b0, -1, 1'b0);
        chk("top_addr_word_lit", mem['h7FFFFF], 32'h007F_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdram_mem_tester.md
Name: sdram_mem_tester

Overview:
Parametrised built-in memory test engine that drives the SDRAM controller command and read-data ports directly. A caller programs an address range, a data pattern mode and a seed, then pulses start. The engine writes the whole range, reads it back, and verifies every word. It reports pass/fail, a saturating error count, first-failure details, and a read timeout, so top-level test sequencers and the UART reporter only consume status.

Parameters:
ADDR_W, 23, width of controller word address
DATA_W, 32, controller data width (multiple of 8)
TIMEOUT, 1024, max cycles from read acceptance to data_out_ready
ERR_CNT_W, 16, width of error_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle request, sampled only in IDLE
mode  in  2  0=incrementing (seed+i), 1=address-as-data, 2=walking-one, 3=LFSR
seed  in  DATA_W  pattern seed, latched on start
addr_start  in  ADDR_W  first address, inclusive, latched on start
addr_end  in  ADDR_W  last address, inclusive, latched on start
stop_on_error  in  1  1=halt at first mismatch, latched on start
cmd_ready  in  1  controller can accept a command
cmd_enable  out  1  command valid
cmd_wr  out  1  1=write, 0=read
cmd_address  out  ADDR_W  command address
cmd_data_in  out  DATA_W  write data
cmd_byte_enable  out  DATA_W/8  constant all ones
data_out  in  DATA_W  read data from controller
data_out_ready  in  1  one-cycle pulse, data_out valid
busy  out  1  test in progress
done  out  1  level, held until the next accepted start
pass  out  1  valid when done, 1 = no mismatch and no timeout
timeout  out  1  read data never returned
error_count  out  ERR_CNT_W  mismatches, saturating at all ones
fail_addr  out  ADDR_W  address of first mismatch
fail_expected  out  DATA_W  expected word at first mismatch
fail_actual  out  DATA_W  read word at first mismatch

Behaviour:
- Reset: all outputs are 0, including cmd_enable, cmd_wr, busy, done, pass and the counters. The FSM goes to IDLE. Reset mid-test aborts the test immediately with no further commands.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE. DONE behaves like IDLE: it accepts start and holds its results.
- start in IDLE/DONE: latch all inputs, clear done, pass, timeout, error_count and the fail_* outputs, set busy, set i=0. If addr_end < addr_start, go to DONE next cycle with pass=1 and issue no commands. Otherwise go to WR_ISSUE; cmd_enable rises the cycle after start.
- start while busy is ignored.
- A command is accepted on any cycle where cmd_enable and cmd_ready are both 1. Address, data and wr stay stable until accepted.
- WR_ISSUE:
  - Present cmd_wr=1, cmd_address=addr_start+i, cmd_data_in=P(i).
  - On accept, increment i and present the next write the very next cycle, so back-to-back writes are allowed.
  - After the addr_end write is accepted, drop cmd_enable for one cycle, reset i and the pattern generator, then go to RD_ISSUE.
- RD_ISSUE: present cmd_wr=0 at address addr_start+i. On accept, drop cmd_enable the next cycle and go to RD_WAIT. Only one read is ever outstanding.
- RD_WAIT:
  - Ignore data_out_ready outside RD_WAIT.
  - On data_out_ready, compare data_out against P(i).
  - On mismatch: increment error_count (saturating). If this is the first error, capture fail_addr, fail_expected and fail_actual.
  - If stop_on_error and a mismatch occurred, go to DONE with pass=0.
  - Otherwise, if this was the last address, go to DONE; else increment i and return to RD_ISSUE.
  - A counter starts on read acceptance. If TIMEOUT cycles elapse with no data_out_ready: timeout=1, pass=0, go to DONE.
- DONE: busy=0, done=1, pass = (error_count==0 && !timeout).
- Pattern P(i), computed at DATA_W width with wrap-around:
  - mode0: seed+i, modulo 2^DATA_W.
  - mode1: addr_start+i, zero-extended or truncated to DATA_W.
  - mode2: seed rotated left by (i mod DATA_W).
  - mode3: Galois LFSR, state initialised to seed and advanced once per accepted word. Seed 0 is replaced by 1. Taps are the maximal-length polynomial for DATA_W (32: 0x80200003). The read pass reproduces the write-pass sequence exactly.
- The address counter never wraps past addr_end. addr_end = 2^ADDR_W-1 is legal.

Test Plan:
- Behavioural SDRAM model with cmd_ready toggling randomly and read latency 3–8 cycles. Mode0, seed=0x100, range 0x10..0x1F → 16 writes then 16 reads, done=1, pass=1, error_count=0.
- Same bench, model corrupts address 0x14 (bit 0 flipped), mode1, stop_on_error=0 → pass=0, error_count=1, fail_addr=0x14, fail_expected=0x14, fail_actual=0x15, all 16 reads issued.
- Corrupt addresses 0x12 and 0x18, stop_on_error=1 → error_count=1, fail_addr=0x12, no read issued after 0x12.
- Mode3, seed=0, range 0..255 → pass=1, first write data=0x00000001. Mode2 seed=1 → address 33 written 0x00000002.
- Model drops the read at address 5, TIMEOUT=1024 → timeout=1 and pass=0 exactly 1024 cycles after acceptance; start pulsed mid-test is ignored.
- addr_end < addr_start → done 1 cycle after start, pass=1, no cmd_enable. Assert rst mid-write → cmd_enable=0 and busy=0 immediately.
